// File: rtl/mem_io_unit.sv
// Data-side memory stage for the single-cycle core: word-addressed data RAM
// plus a memory-mapped IO window at 0xFFFF_xxxx. The window holds an LED
// register, a free-running cycle counter and a compare timer with interrupt.
// Optional feature macro: BOUNDS_CHECK_EN. It flags out-of-range RAM accesses
// with a sticky bus_err, suppresses those writes and returns 32'hDEADBEEF.
// With the macro undefined, high address bits alias the RAM and bus_err is 0.
module mem_io_unit #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LED_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [31:0]      addr,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [LED_W-1:0] led,
  output logic             irq,
  output logic             bus_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  // IO register word offsets (addr[7:2])
  localparam logic [5:0] OFF_LED   = 6'd0;
  localparam logic [5:0] OFF_CYCLE = 6'd1;
  localparam logic [5:0] OFF_CMP   = 6'd2;
  localparam logic [5:0] OFF_CTRL  = 6'd3;
  localparam logic [5:0] OFF_CNT   = 6'd4;

  // Address decode
  logic          w_is_io;
  logic          w_io_ok;
  logic [5:0]    w_off;
  logic [AW-1:0] w_ram_idx;
  logic          w_oor;
  logic          w_unused_addr;

  assign w_is_io   = (addr[31:16] == 16'hFFFF);
  assign w_io_ok   = w_is_io && (addr[15:8] == 8'h00);
  assign w_off     = addr[7:2];
  assign w_ram_idx = addr[AW+1:2];
  // Byte-lane bits and, depending on DEPTH_WORDS, some high bits never matter
  assign w_unused_addr = ^addr;

`ifdef BOUNDS_CHECK_EN
  assign w_oor = ~w_is_io & (|addr[31:AW+2]);
`else
  assign w_oor = 1'b0;
`endif

  // Write strobes
  logic w_io_we;
  logic w_we_led;
  logic w_we_cycle;
  logic w_we_cmp;
  logic w_we_ctrl;
  logic w_we_cnt;
  logic w_ram_we;

  assign w_io_we    = memwrite && w_io_ok;
  assign w_we_led   = w_io_we && (w_off == OFF_LED);
  assign w_we_cycle = w_io_we && (w_off == OFF_CYCLE);
  assign w_we_cmp   = w_io_we && (w_off == OFF_CMP);
  assign w_we_ctrl  = w_io_we && (w_off == OFF_CTRL);
  assign w_we_cnt   = w_io_we && (w_off == OFF_CNT);
  assign w_ram_we   = memwrite && !w_is_io && !w_oor;

  // State
  logic [31:0]      r_ram [DEPTH_WORDS];
  logic [LED_W-1:0] r_led;
  logic [31:0]      r_cycle;
  logic [31:0]      r_tmr_cmp;
  logic [31:0]      r_tmr_cnt;
  logic             r_tmr_en;
  logic             r_tmr_ar;
  logic             r_tmr_flag;

  // Compare hit only counts while the timer is running
  logic w_match;
  assign w_match = r_tmr_en && (r_tmr_cnt == r_tmr_cmp);

  // Data RAM: synchronous write, contents deliberately not reset
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_ram[w_ram_idx] <= writedata;
    end
  end

  // LED register and compare value: plain software-owned registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led     <= '0;
      r_tmr_cmp <= '0;
    end else begin
      if (w_we_led) r_led     <= writedata[LED_W-1:0];
      if (w_we_cmp) r_tmr_cmp <= writedata;
    end
  end

  // Free-running cycle counter; a software load wins over the increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle <= '0;
    end else if (w_we_cycle) begin
      r_cycle <= writedata;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  // Timer count: software write beats hardware increment/reload
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmr_cnt <= '0;
    end else if (w_we_cnt) begin
      r_tmr_cnt <= writedata;
    end else if (r_tmr_en) begin
      if (!w_match) begin
        r_tmr_cnt <= r_tmr_cnt + 32'd1;
      end else if (r_tmr_ar) begin
        r_tmr_cnt <= '0;
      end
    end
  end

  // Timer control: en/autoreload from software, one-shot match drops en,
  // and a hardware flag set beats a same-cycle write-1-to-clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmr_en   <= 1'b0;
      r_tmr_ar   <= 1'b0;
      r_tmr_flag <= 1'b0;
    end else begin
      if (w_we_ctrl) begin
        r_tmr_en <= writedata[0];
        r_tmr_ar <= writedata[2];
      end else if (w_match && !r_tmr_ar) begin
        r_tmr_en <= 1'b0;
      end
      if (w_match) begin
        r_tmr_flag <= 1'b1;
      end else if (w_we_ctrl && writedata[1]) begin
        r_tmr_flag <= 1'b0;
      end
    end
  end

`ifdef BOUNDS_CHECK_EN
  logic r_bus_err;

  // Sticky out-of-range flag, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bus_err <= 1'b0;
    end else if (w_oor) begin
      r_bus_err <= 1'b1;
    end
  end

  assign bus_err = r_bus_err;
`else
  assign bus_err = 1'b0;
`endif

  // Combinational load path from the current address and pre-edge state
  always_comb begin
    readdata = 32'h0;
    if (w_is_io) begin
      if (w_io_ok) begin
        case (w_off)
          OFF_LED:   readdata = 32'(r_led);
          OFF_CYCLE: readdata = r_cycle;
          OFF_CMP:   readdata = r_tmr_cmp;
          OFF_CTRL:  readdata = {29'h0, r_tmr_ar, r_tmr_flag, r_tmr_en};
          OFF_CNT:   readdata = r_tmr_cnt;
          default:   readdata = 32'h0;
        endcase
      end
    end else if (w_oor) begin
      readdata = 32'hDEADBEEF;
    end else begin
      readdata = r_ram[w_ram_idx];
    end
  end

  assign led = r_led;
  assign irq = r_tmr_flag;

endmodule

// File: tb/tb_mem_io_unit.sv
// Self-checking bench for mem_io_unit: directed scenarios followed by random
// traffic, all compared against a behavioural model of the memory map.
// Honours BOUNDS_CHECK_EN the same way the design does.
module tb_mem_io_unit;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned LED_W = 8;
  localparam int unsigned AW    = $clog2(DEPTH);

  localparam logic [31:0] A_LED  = 32'hFFFF_0000;
  localparam logic [31:0] A_CYC  = 32'hFFFF_0004;
  localparam logic [31:0] A_CMP  = 32'hFFFF_0008;
  localparam logic [31:0] A_CTRL = 32'hFFFF_000C;
  localparam logic [31:0] A_CNT  = 32'hFFFF_0010;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             memwrite = 1'b0;
  logic [31:0]      addr = 32'h0;
  logic [31:0]      writedata = 32'h0;
  logic [31:0]      readdata;
  logic [LED_W-1:0] led;
  logic             irq;
  logic             bus_err;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model of the architectural state
  logic [31:0]      m_ram [DEPTH];
  logic [31:0]      m_cycle, m_cmp, m_cnt;
  logic [LED_W-1:0] m_led;
  logic             m_en, m_ar, m_flag, m_berr;

  always #5 clk = ~clk;

  mem_io_unit #(
    .DEPTH_WORDS(DEPTH),
    .LED_W      (LED_W)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .memwrite (memwrite),
    .addr     (addr),
    .writedata(writedata),
    .readdata (readdata),
    .led      (led),
    .irq      (irq),
    .bus_err  (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_cycle = 0; m_cmp = 0; m_cnt = 0; m_led = 0;
    m_en = 0; m_ar = 0; m_flag = 0; m_berr = 0;
  endfunction

  function automatic logic m_oor(input logic [31:0] a);
`ifdef BOUNDS_CHECK_EN
    return (a[31:16] != 16'hFFFF) && ((a >> (AW + 2)) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int unsigned off;
    if (a[31:16] == 16'hFFFF) begin
      if (a[15:8] != 8'h00) return 32'h0;
      off = int'(a[7:0]) / 4;
      case (off)
        0: return 32'(m_led);
        1: return m_cycle;
        2: return m_cmp;
        3: return {29'h0, m_ar, m_flag, m_en};
        4: return m_cnt;
        default: return 32'h0;
      endcase
    end
    if (m_oor(a)) return 32'hDEADBEEF;
    return m_ram[(a / 4) % DEPTH];
  endfunction

  // Apply one clock edge of spec behaviour to the model
  function automatic void m_edge(input logic we, input logic [31:0] a, input logic [31:0] d);
    logic        io_ok, hw_set;
    int unsigned off;
    logic [31:0] n_cnt;
    logic        n_en;
    io_ok  = (a[31:16] == 16'hFFFF) && (a[15:8] == 8'h00);
    off    = int'(a[7:0]) / 4;
    hw_set = 1'b0;
    n_cnt  = m_cnt;
    n_en   = m_en;
    if (m_en) begin
      if (m_cnt == m_cmp) begin
        hw_set = 1'b1;
        if (m_ar) n_cnt = 0;
        else n_en = 1'b0;
      end else begin
        n_cnt = m_cnt + 1;
      end
    end
    m_cycle = m_cycle + 1;
    if (we && io_ok) begin
      case (off)
        0: m_led = d[LED_W-1:0];
        1: m_cycle = d;
        2: m_cmp = d;
        3: begin
          n_en = d[0];
          m_ar = d[2];
          if (d[1]) m_flag = 1'b0;
        end
        4: n_cnt = d;
        default: ;
      endcase
    end
    if (hw_set) m_flag = 1'b1;
    m_cnt = n_cnt;
    m_en  = n_en;
    if (a[31:16] != 16'hFFFF) begin
      if (m_oor(a)) m_berr = 1'b1;
      else if (we) m_ram[(a / 4) % DEPTH] = d;
    end
  endfunction

  // One bus cycle, entered and left at a falling edge
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
    memwrite  = we;
    addr      = a;
    writedata = d;
    #2;
    check("readdata", readdata, m_read(a));
    @(posedge clk);
    m_edge(we, a, d);
    #1;
    check("led", 32'(led), 32'(m_led));
    check("irq", 32'(irq), 32'(m_flag));
    check("bus_err", 32'(bus_err), 32'(m_berr));
    @(negedge clk);
  endtask

  // Look at readdata for an address without advancing the clock
  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    memwrite = 1'b0;
    addr     = a;
    #1;
    check(tag, readdata, exp);
  endtask

  logic [31:0] old0, a, d;
  int          n, sel;

  initial begin
    m_reset();
    addr = A_CYC;
    repeat (2) @(negedge clk);
    check("rst_cycle", readdata, 32'h0);
    check("rst_led", 32'(led), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_berr", 32'(bus_err), 32'h0);
    reset = 1'b1;

    // Give every RAM word a known value
    for (int i = 0; i < int'(DEPTH); i++) step(1'b1, 32'(i) << 2, $urandom);

    // Store then load
    step(1'b1, 32'h0000_0010, 32'h1234_5678);
    peek("ram_rd", 32'h0000_0010, 32'h1234_5678);

    // Cycle counter load
    step(1'b1, A_CYC, 32'd100);
    peek("cycle_load", A_CYC, 32'd100);
    step(1'b0, A_CYC, 32'h0);
    peek("cycle_inc", A_CYC, 32'd101);

    // Autoreload timer period
    step(1'b1, A_CNT, 32'd0);
    step(1'b1, A_CMP, 32'd5);
    step(1'b1, A_CTRL, 32'h5);
    n = 0;
    while (irq !== 1'b1 && n < 20) begin
      step(1'b0, A_CNT, 32'h0);
      n++;
    end
    check("irq_lat", 32'(n), 32'd6);
    step(1'b1, A_CTRL, 32'h7);
    check("irq_w1c", 32'(irq), 32'h0);
    n = 1;
    while (irq !== 1'b1 && n < 20) begin
      step(1'b0, A_CNT, 32'h0);
      n++;
    end
    check("irq_reload_lat", 32'(n), 32'd6);

    // One-shot timer
    step(1'b1, A_CTRL, 32'h2);
    step(1'b1, A_CNT, 32'd0);
    step(1'b1, A_CMP, 32'd3);
    step(1'b1, A_CTRL, 32'h1);
    repeat (4) step(1'b0, A_CTRL, 32'h0);
    peek("oneshot_ctrl", A_CTRL, 32'h2);
    peek("oneshot_cnt", A_CNT, 32'd3);

    // W1C landing on the match edge loses to the hardware set
    step(1'b1, A_CTRL, 32'h2);
    check("flag_clr", 32'(irq), 32'h0);
    step(1'b1, A_CNT, 32'd0);
    step(1'b1, A_CTRL, 32'h1);
    repeat (3) step(1'b0, A_CNT, 32'h0);
    step(1'b1, A_CTRL, 32'h2);
    peek("w1c_race_ctrl", A_CTRL, 32'h2);
    check("w1c_race_irq", 32'(irq), 32'h1);

    // Out-of-range RAM store
    old0 = m_ram[0];
    step(1'b1, 32'h0000_0100, 32'hCAFE_F00D);
`ifdef BOUNDS_CHECK_EN
    peek("oor_ram0", 32'h0000_0000, old0);
    repeat (3) step(1'b0, 32'h0000_0004, 32'h0);
    check("berr_sticky", 32'(bus_err), 32'h1);
`else
    peek("alias_ram0", 32'h0000_0000, 32'hCAFE_F00D);
    repeat (3) step(1'b0, 32'h0000_0004, 32'h0);
    check("berr_tied", 32'(bus_err), 32'h0);
`endif

    // Asynchronous reset in the middle of a cycle
    step(1'b1, A_LED, 32'h0000_00A5);
    step(1'b1, A_CYC, 32'd37);
    peek("pre_rst_cycle", A_CYC, 32'd37);
    check("pre_rst_led", 32'(led), 32'h0000_00A5);
    #1 reset = 1'b0;
    #1;
    m_reset();
    check("mid_rst_cycle", readdata, 32'h0);
    check("mid_rst_led", 32'(led), 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    check("mid_rst_berr", 32'(bus_err), 32'h0);
    @(posedge clk);
    #1;
    check("hold_rst_cycle", readdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    peek("ram_kept", 32'h0000_0010, 32'h1234_5678);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 4) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
      else if (sel == 5) a = $urandom;
      else if (sel <= 8) a = A_LED | (32'($urandom_range(0, 4)) << 2) | 32'($urandom_range(0, 3));
      else a = A_LED | 32'($urandom_range(0, 16'hFFFF));
      d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 12));
      step(1'($urandom_range(0, 1)), a, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
